// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Runs one convolution layer. It fetches the weight/bias words, then handles
//   each output pixel in turn: clear the PE accumulators, read every input tap,
//   and issue one output write followed by a fixed serialisation window.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start               launch pulse, honoured only while idle
//   cfg_*               layer configuration, latched on an accepted start
//   rdv_input/weight    read data-valid returned by the PE array top
//   conv_num, relu_en,
//   pool_en             latched configuration driven to the PE array
//   rst_n_pe            active-low accumulator clear (low in CLR and in reset)
//   partial_en          accumulate onto the partial sum (every tap but the first)
//   output_en           high for the whole serialisation window
//   addr_/en_readw      weight-read request
//   addr_/en_readi      input-read request
//   addr_/en_write      output-write request
//   busy, done          not-idle flag, one-cycle completion pulse
//   err_timeout         sticky: a read-valid never arrived
module conv_layer_sequencer #(
  parameter int WR_CYCLES = 70,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cfg_conv_num,
  input  logic        cfg_relu_en,
  input  logic        cfg_pool_en,
  input  logic [16:0] cfg_w_base,
  input  logic [7:0]  cfg_w_words,
  input  logic [16:0] cfg_i_base,
  input  logic [11:0] cfg_taps,
  input  logic [14:0] cfg_o_base,
  input  logic [14:0] cfg_pixels,
  input  logic        rdv_input,
  input  logic        rdv_weight,
  output logic [3:0]  conv_num,
  output logic        rst_n_pe,
  output logic        partial_en,
  output logic        relu_en,
  output logic        pool_en,
  output logic        output_en,
  output logic [16:0] addr_readw,
  output logic        en_readw,
  output logic [16:0] addr_readi,
  output logic        en_readi,
  output logic [14:0] addr_write,
  output logic        en_write,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_REQ  = 3'd1;
  localparam logic [2:0] W_WAIT = 3'd2;
  localparam logic [2:0] CLR    = 3'd3;
  localparam logic [2:0] I_REQ  = 3'd4;
  localparam logic [2:0] I_WAIT = 3'd5;
  localparam logic [2:0] WR     = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  // Terminal counts; a parameter below 1 behaves as 1.
  localparam int WR_LAST_I = (WR_CYCLES > 1) ? WR_CYCLES - 1 : 0;
  localparam int WC_W      = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;
  localparam int TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(WR_LAST_I);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

  logic [2:0]      state_reg;
  logic [3:0]      conv_num_reg;
  logic            relu_reg;
  logic            pool_reg;
  logic [16:0]     w_base_reg;
  logic [7:0]      w_words_reg;
  logic [16:0]     i_base_reg;
  logic [11:0]     taps_reg;
  logic [14:0]     o_base_reg;
  logic [14:0]     pixels_reg;
  logic [7:0]      w_idx_reg;
  logic [11:0]     tap_idx_reg;
  logic [14:0]     pix_idx_reg;
  logic [TO_W-1:0] wait_cnt_reg;
  logic [WC_W-1:0] wr_cnt_reg;
  logic            err_reg;
  logic            rst_n_pe_reg;

  logic            w_last;
  logic            tap_last;
  logic            pix_last;
  logic [16:0]     addr_i_calc;

  // Counts are stored with 0 already mapped to 1, so "last" is always count-1.
  assign w_last   = (w_idx_reg == w_words_reg - 8'd1);
  assign tap_last = (tap_idx_reg == taps_reg - 12'd1);
  assign pix_last = (pix_idx_reg == pixels_reg - 15'd1);

  // Full 27-bit product, truncated to the 17-bit read address space.
  assign addr_i_calc = i_base_reg + 17'(27'(pix_idx_reg) * 27'(taps_reg))
                       + 17'(tap_idx_reg);

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign en_readw    = (state_reg == W_REQ);
  assign en_readi    = (state_reg == I_REQ);
  assign en_write    = (state_reg == WR) && (wr_cnt_reg == '0);
  assign output_en   = (state_reg == WR);
  assign partial_en  = ((state_reg == I_REQ) || (state_reg == I_WAIT)) &&
                       (tap_idx_reg != 12'd0);
  // Addresses are forced to zero outside their request cycle.
  assign addr_readw  = en_readw ? (w_base_reg + 17'(w_idx_reg)) : 17'd0;
  assign addr_readi  = en_readi ? addr_i_calc : 17'd0;
  assign addr_write  = en_write ? (o_base_reg + pix_idx_reg) : 15'd0;
  assign conv_num    = conv_num_reg;
  assign relu_en     = relu_reg;
  assign pool_en     = pool_reg;
  assign err_timeout = err_reg;
  // Registered so the clear is also held low while reset is asserted.
  assign rst_n_pe    = rst_n_pe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      conv_num_reg <= '0;
      relu_reg     <= 1'b0;
      pool_reg     <= 1'b0;
      w_base_reg   <= '0;
      w_words_reg  <= '0;
      i_base_reg   <= '0;
      taps_reg     <= '0;
      o_base_reg   <= '0;
      pixels_reg   <= '0;
      w_idx_reg    <= '0;
      tap_idx_reg  <= '0;
      pix_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      wr_cnt_reg   <= '0;
      err_reg      <= 1'b0;
      rst_n_pe_reg <= 1'b0;
    end else begin
      rst_n_pe_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            conv_num_reg <= cfg_conv_num;
            relu_reg     <= cfg_relu_en;
            pool_reg     <= cfg_pool_en;
            w_base_reg   <= cfg_w_base;
            w_words_reg  <= (cfg_w_words == 8'd0) ? 8'd1 : cfg_w_words;
            i_base_reg   <= cfg_i_base;
            taps_reg     <= (cfg_taps == 12'd0) ? 12'd1 : cfg_taps;
            o_base_reg   <= cfg_o_base;
            pixels_reg   <= (cfg_pixels == 15'd0) ? 15'd1 : cfg_pixels;
            w_idx_reg    <= '0;
            tap_idx_reg  <= '0;
            pix_idx_reg  <= '0;
            wait_cnt_reg <= '0;
            wr_cnt_reg   <= '0;
            err_reg      <= 1'b0;
            state_reg    <= W_REQ;
          end
        end
        W_REQ: begin
          wait_cnt_reg <= '0;
          state_reg    <= W_WAIT;
        end
        W_WAIT: begin
          // Only the weight valid is looked at, and only from this state on.
          if (rdv_weight) begin
            w_idx_reg <= w_idx_reg + 8'd1;
            if (w_last) begin
              state_reg    <= CLR;
              rst_n_pe_reg <= 1'b0;
            end else begin
              state_reg <= W_REQ;
            end
          end else if (wait_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
          end
        end
        CLR: begin
          tap_idx_reg <= '0;
          state_reg   <= I_REQ;
        end
        I_REQ: begin
          wait_cnt_reg <= '0;
          state_reg    <= I_WAIT;
        end
        I_WAIT: begin
          if (rdv_input) begin
            tap_idx_reg <= tap_idx_reg + 12'd1;
            if (tap_last) begin
              wr_cnt_reg <= '0;
              state_reg  <= WR;
            end else begin
              state_reg <= I_REQ;
            end
          end else if (wait_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
          end
        end
        WR: begin
          // The write address uses pix_idx, so it only advances once the
          // serialisation window is over.
          if (wr_cnt_reg == WR_LAST) begin
            pix_idx_reg <= pix_idx_reg + 15'd1;
            if (pix_last) begin
              state_reg <= DONE;
            end else begin
              state_reg    <= CLR;
              rst_n_pe_reg <= 1'b0;
            end
          end else begin
            wr_cnt_reg <= wr_cnt_reg + WC_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
